// File: rtl/tcdm_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_pkg
// Shared types and constants for the TCDM memory responder:
//   - tcdm_resp_t    : one response beat {valid, opc, rdata}
//   - TCDM_ERR_RDATA : default read data for out-of-window reads
//   - TCDM_WEN_READ  : wen value that marks a read (TCDM polarity, 1 = read)
// -----------------------------------------------------------------------------
package tcdm_pkg;

  localparam logic        TCDM_WEN_READ  = 1'b1;
  localparam logic [31:0] TCDM_ERR_RDATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic        valid;
    logic        opc;
    logic [31:0] rdata;
  } tcdm_resp_t;

endpackage

// File: rtl/tcdm_mem_responder_resp_pipe.sv
// -----------------------------------------------------------------------------
// tcdm_resp_pipe
// Fixed-depth delay line for response beats. Only the valid bits are reset so
// that in-flight responses vanish on reset; the payload is plain data.
// DEPTH = 0 is a straight wire.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset (clears valid bits)
//   resp_i  in   response beat entering the line
//   resp_o  out  response beat leaving the line, DEPTH cycles later
// -----------------------------------------------------------------------------
module tcdm_resp_pipe
  import tcdm_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  tcdm_resp_t resp_i,
  output tcdm_resp_t resp_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign resp_o = resp_i;
  end else begin : g_stages
    logic        valid_q [DEPTH];
    logic        opc_q   [DEPTH];
    logic [31:0] rdata_q [DEPTH];
    tcdm_resp_t  stage_in [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = resp_i;
      end else begin : g_next
        assign stage_in[gi] = '{valid: valid_q[gi-1], opc: opc_q[gi-1], rdata: rdata_q[gi-1]};
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q[gi] <= 1'b0;
        end else begin
          valid_q[gi] <= stage_in[gi].valid;
        end
      end

      always_ff @(posedge clk_i) begin
        opc_q[gi]   <= stage_in[gi].opc;
        rdata_q[gi] <= stage_in[gi].rdata;
      end
    end

    assign resp_o = '{valid: valid_q[DEPTH-1], opc: opc_q[DEPTH-1], rdata: rdata_q[DEPTH-1]};
  end

endmodule

// File: rtl/tcdm_mem_responder.sv
// -----------------------------------------------------------------------------
// tcdm_mem_responder
// Responder end of a TCDM req/gnt/r_valid port backed by a word-addressed
// local array. Grants requests combinationally (optionally stalling every
// STALL_PERIOD-th grant for one cycle), writes at the grant edge with byte
// enables, reads read-first at the grant edge, and returns one response per
// transfer RESP_LATENCY cycles later, strictly in order. Accesses outside
// [BASE_ADDR, BASE_ADDR + NUM_WORDS*4) leave the array alone and set r_opc.
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   req_i      in   request valid
//   add_i      in   byte address ([1:0] ignored)
//   wen_i      in   1 = read, 0 = write
//   wdata_i    in   write data
//   be_i       in   write byte enables
//   gnt_o      out  grant (combinational)
//   r_valid_o  out  response valid
//   r_rdata_o  out  read data (0 when not valid or for writes)
//   r_opc_o    out  1 = access was outside the window
// -----------------------------------------------------------------------------
module tcdm_mem_responder
  import tcdm_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h1C00_0000,
  parameter int unsigned RESP_LATENCY = 1,
  parameter int unsigned STALL_PERIOD = 0,
  parameter logic [31:0] ERR_RDATA    = TCDM_ERR_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        r_valid_o,
  output logic [31:0] r_rdata_o,
  output logic        r_opc_o
);

  localparam int unsigned AW           = $clog2(NUM_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(NUM_WORDS * 4);
  localparam int unsigned CNT_W        = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic        STALL_EN     = (STALL_PERIOD > 0);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (NUM_WORDS < 16 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_num_words
    $error("tcdm_mem_responder: NUM_WORDS must be a power of two >= 16");
  end
  if ((BASE_ADDR % (NUM_WORDS * 4)) != 0) begin : g_bad_base
    $error("tcdm_mem_responder: BASE_ADDR must be aligned to NUM_WORDS*4");
  end
  if (RESP_LATENCY < 1 || RESP_LATENCY > 4) begin : g_bad_latency
    $error("tcdm_mem_responder: RESP_LATENCY must be in 1..4");
  end

  // ---------------------------------------------------------------------------
  // Grant and stall counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stalled_q, stalled_d;   // IDLE = 0, STALL = 1
  logic             stall_now;
  logic             transfer;

  always_comb begin
    // stalled_q blocks a second stall so the held request is granted next cycle
    stall_now = STALL_EN && req_i && !stalled_q && (stall_cnt_q == CNT_LAST);
    gnt_o     = req_i && !stall_now;
    transfer  = gnt_o;

    stall_cnt_d = stall_cnt_q;
    if (transfer) begin
      stall_cnt_d = (stall_cnt_q == CNT_LAST) ? '0 : stall_cnt_q + 1'b1;
    end

    stalled_d = stalled_q;
    if (stall_now) begin
      stalled_d = 1'b1;
    end else if (transfer) begin
      stalled_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      stalled_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stalled_q   <= stalled_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode: one unsigned subtract covers both window bounds
  // ---------------------------------------------------------------------------
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          is_read;
  logic          unused_offset_bits;

  assign offset             = add_i - BASE_ADDR;
  assign in_range           = offset < WINDOW_BYTES;
  assign word_idx           = offset[AW+1:2];
  assign is_read            = (wen_i == TCDM_WEN_READ);
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  // ---------------------------------------------------------------------------
  // Memory array (not reset); read data registered at the grant edge
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [NUM_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (transfer && in_range) begin
      if (is_read) begin
        rd_data_q <= mem_q[word_idx];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First response stage: control flags registered alongside the array read
  // ---------------------------------------------------------------------------
  logic s0_valid_q, s0_valid_d;
  logic s0_opc_q, s0_opc_d;
  logic s0_ok_rd_q, s0_ok_rd_d;
  logic s0_err_rd_q, s0_err_rd_d;

  always_comb begin
    s0_valid_d  = transfer;
    s0_opc_d    = transfer && !in_range;
    s0_ok_rd_d  = transfer && in_range && is_read;
    s0_err_rd_d = transfer && !in_range && is_read;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q  <= 1'b0;
      s0_opc_q    <= 1'b0;
      s0_ok_rd_q  <= 1'b0;
      s0_err_rd_q <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_opc_q    <= s0_opc_d;
      s0_ok_rd_q  <= s0_ok_rd_d;
      s0_err_rd_q <= s0_err_rd_d;
    end
  end

  tcdm_resp_t s0_resp;
  tcdm_resp_t out_resp;

  always_comb begin
    s0_resp.valid = s0_valid_q;
    s0_resp.opc   = s0_opc_q;
    if (s0_ok_rd_q) begin
      s0_resp.rdata = rd_data_q;
    end else if (s0_err_rd_q) begin
      s0_resp.rdata = ERR_RDATA;
    end else begin
      s0_resp.rdata = '0;
    end
  end

  // The first stage above already supplies one cycle of latency
  tcdm_resp_pipe #(
    .DEPTH (RESP_LATENCY - 1)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (s0_resp),
    .resp_o (out_resp)
  );

  // Payload is forced to zero whenever no response is presented
  assign r_valid_o = out_resp.valid;
  assign r_opc_o   = out_resp.valid & out_resp.opc;
  assign r_rdata_o = out_resp.valid ? out_resp.rdata : 32'h0;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_tcdm_mem_responder
// Directed bench with three responder instances sharing address/data inputs:
//   u_dut_a : 1024 words, latency 1, no stalls
//   u_dut_b : 64 words, latency 3, no stalls
//   u_dut_c : 64 words, latency 1, stall every 4th grant
// Each instance has its own req line so only the one under test sees requests.
// -----------------------------------------------------------------------------
module tb_tcdm_mem_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b, req_c;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt_a, gnt_b, gnt_c;
  logic        r_valid_a, r_valid_b, r_valid_c;
  logic [31:0] r_rdata_a, r_rdata_b, r_rdata_c;
  logic        r_opc_a, r_opc_b, r_opc_c;

  int checks = 0;
  int errors = 0;

  tcdm_mem_responder #(
    .NUM_WORDS(1024), .BASE_ADDR(BASE), .RESP_LATENCY(1), .STALL_PERIOD(0)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .r_valid_o(r_valid_a),
    .r_rdata_o(r_rdata_a), .r_opc_o(r_opc_a)
  );

  tcdm_mem_responder #(
    .NUM_WORDS(64), .BASE_ADDR(BASE), .RESP_LATENCY(3), .STALL_PERIOD(0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .r_valid_o(r_valid_b),
    .r_rdata_o(r_rdata_b), .r_opc_o(r_opc_b)
  );

  tcdm_mem_responder #(
    .NUM_WORDS(64), .BASE_ADDR(BASE), .RESP_LATENCY(1), .STALL_PERIOD(4)
  ) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_c), .r_valid_o(r_valid_c),
    .r_rdata_o(r_rdata_c), .r_opc_o(r_opc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Single transfer on u_dut_a, called at a falling edge; returns at a falling
  // edge one idle cycle after the response.
  task automatic txn_a(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_opc);
    req_a = 1'b1; add = a; wen = w; wdata = wd; be = b;
    #1 check($sformatf("%s_gnt", tag), 32'(gnt_a), 32'd1);
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    check($sformatf("%s_valid", tag), 32'(r_valid_a), 32'd1);
    check($sformatf("%s_rdata", tag), r_rdata_a, exp_rd);
    check($sformatf("%s_opc", tag), 32'(r_opc_a), 32'(exp_opc));
    $display("txn %s: addr=%08h wen=%0b wdata=%08h be=%h -> rdata=%08h opc=%0b",
             tag, a, w, wd, b, r_rdata_a, r_opc_a);
    @(negedge clk);
    check($sformatf("%s_idle", tag), 32'(r_valid_a), 32'd0);
  endtask

  // Eight back-to-back transfers to words 0..7 of u_dut_b (latency 3).
  // Writes store 0x1111_0000+k; reads expect that data back in order.
  task automatic burst_b(input logic rd);
    for (int i = 0; i < 12; i++) begin
      logic        exp_v;
      logic [31:0] exp_d;
      exp_v = (i >= 3) && (i < 11);
      exp_d = (exp_v && rd) ? 32'h1111_0000 + 32'(i - 3) : 32'h0;
      check($sformatf("burst%0d_valid_c%0d", rd, i), 32'(r_valid_b), 32'(exp_v));
      check($sformatf("burst%0d_rdata_c%0d", rd, i), r_rdata_b, exp_d);
      if (exp_v) begin
        $display("txn burst rd=%0b beat %0d: rdata=%08h opc=%0b", rd, i - 3, r_rdata_b, r_opc_b);
      end
      req_b = (i < 8);
      add   = BASE + 32'(4 * i);
      wen   = rd;
      wdata = 32'h1111_0000 + 32'(i);
      be    = 4'hF;
      #1 check($sformatf("burst%0d_gnt_c%0d", rd, i), 32'(gnt_b), 32'(i < 8));
      @(negedge clk);
    end
    req_b = 1'b0;
  endtask

  initial begin
    logic [11:0] gnt_pat;
    int          sent;
    int          resp;

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    add = 32'h0; wen = 1'b1; wdata = 32'h0; be = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_valid_a", 32'(r_valid_a), 32'd0);
    check("rst_rdata_a", r_rdata_a, 32'h0);
    check("rst_opc_a", 32'(r_opc_a), 32'd0);
    check("rst_valid_b", 32'(r_valid_b), 32'd0);
    check("rst_valid_c", 32'(r_valid_c), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read, partial byte write, empty byte-enable write
    txn_a("wr_beef",   BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    txn_a("rd_beef",   BASE + 32'h10, 1'b1, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    txn_a("wr_be2",    BASE + 32'h10, 1'b0, 32'h0000_5500, 4'b0010, 32'h0, 1'b0);
    txn_a("rd_be2",    BASE + 32'h10, 1'b1, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0);
    txn_a("wr_be0",    BASE + 32'h10, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    txn_a("rd_be0",    BASE + 32'h10, 1'b1, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0);

    // Window edges, then out-of-range accesses that would alias onto them
    txn_a("wr_first",  BASE,           1'b0, 32'h0123_4567, 4'hF, 32'h0, 1'b0);
    txn_a("wr_last",   BASE + 32'hFFC, 1'b0, 32'h89AB_CDEF, 4'hF, 32'h0, 1'b0);
    txn_a("rd_below",  32'h1BFF_FFFC,  1'b1, 32'h0, 4'h0, 32'hBADA_CCE5, 1'b1);
    txn_a("rd_above",  BASE + 32'h1000, 1'b1, 32'h0, 4'h0, 32'hBADA_CCE5, 1'b1);
    txn_a("wr_below",  32'h1BFF_FFFC,  1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    txn_a("wr_above",  BASE + 32'h1000, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    txn_a("rd_first",  BASE,           1'b1, 32'h0, 4'h0, 32'h0123_4567, 1'b0);
    txn_a("rd_last",   BASE + 32'hFFC, 1'b1, 32'h0, 4'h0, 32'h89AB_CDEF, 1'b0);

    // Read granted the cycle right after a write to the same word
    req_a = 1'b1; add = BASE + 32'h20; wen = 1'b0; wdata = 32'hCAFE_F00D; be = 4'hF;
    @(posedge clk); #1 wen = 1'b1;
    @(negedge clk);
    check("raw_wr_valid", 32'(r_valid_a), 32'd1);
    check("raw_wr_rdata", r_rdata_a, 32'h0);
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    check("raw_rd_valid", 32'(r_valid_a), 32'd1);
    check("raw_rd_rdata", r_rdata_a, 32'hCAFE_F00D);
    $display("txn raw: addr=%08h -> rdata=%08h", BASE + 32'h20, r_rdata_a);
    @(negedge clk);

    // Latency 3: back-to-back writes then back-to-back reads
    burst_b(1'b0);
    burst_b(1'b1);

    // Stall every 4th grant: expected grant per cycle for 10 requests
    gnt_pat = 12'b1110_1111_0111;
    sent = 0;
    resp = 0;
    for (int i = 0; i < 14; i++) begin
      logic exp_v;
      exp_v = (i >= 1 && i <= 12) ? gnt_pat[i-1] : 1'b0;
      check($sformatf("stall_valid_c%0d", i), 32'(r_valid_c), 32'(exp_v));
      if (r_valid_c) begin
        resp++;
        $display("txn stall resp %0d: rdata=%08h opc=%0b", resp, r_rdata_c, r_opc_c);
      end
      req_c = (sent < 10);
      add   = BASE + 32'(4 * sent);
      wen   = 1'b0;
      wdata = 32'(sent);
      be    = 4'hF;
      #1 check($sformatf("stall_gnt_c%0d", i), 32'(gnt_c), 32'((i < 12) ? gnt_pat[i] : 1'b0));
      if (gnt_c) sent++;
      @(negedge clk);
    end
    req_c = 1'b0;
    check("stall_sent", 32'(sent), 32'd10);
    check("stall_resp", 32'(resp), 32'd10);

    // Reset with responses in flight on the latency-3 instance
    for (int i = 0; i < 3; i++) begin
      req_b = 1'b1; add = BASE + 32'(4 * i); wen = 1'b1; be = 4'h0;
      @(negedge clk);
    end
    req_b = 1'b0;
    check("inflight_valid", 32'(r_valid_b), 32'd1);
    check("inflight_rdata", r_rdata_b, 32'h1111_0000);
    rst_n = 1'b0;
    #1;
    check("async_drop_valid", 32'(r_valid_b), 32'd0);
    check("async_drop_rdata", r_rdata_b, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_valid_c%0d", i), 32'(r_valid_b), 32'd0);
    end

    // Committed write survives reset
    req_b = 1'b1; add = BASE + 32'h14; wen = 1'b1;
    #1 check("post_rst_gnt", 32'(gnt_b), 32'd1);
    @(posedge clk); #1 req_b = 1'b0;
    @(negedge clk); check("post_rst_lat1", 32'(r_valid_b), 32'd0);
    @(negedge clk); check("post_rst_lat2", 32'(r_valid_b), 32'd0);
    @(negedge clk);
    check("post_rst_lat3", 32'(r_valid_b), 32'd1);
    check("post_rst_rdata", r_rdata_b, 32'h1111_0005);
    $display("txn post-reset read: addr=%08h -> rdata=%08h", BASE + 32'h14, r_rdata_b);
    @(negedge clk);
    check("post_rst_done", 32'(r_valid_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_mem_responder.md
Name: tcdm_mem_responder

Overview:
- Target (responder) end of the XBAR_TCDM_BUS req/gnt/r_valid protocol that the fabric controller core drives on its L2 data and instruction ports.
- Holds a word-addressed local memory array, grants requests, and returns read data or write acknowledges after a fixed, parameterised latency. It flags out-of-range accesses on r_opc.
- Configurable grant-stall injection lets the same block stand in as a bench L2 model and as a small private scratchpad in the SoC.

Parameters:
- NUM_WORDS, 1024, number of 32-bit words in the array; power of two, ≥16.
- BASE_ADDR, 32'h1C00_0000, byte base address of the window; aligned to NUM_WORDS*4.
- RESP_LATENCY, 1, cycles from the grant edge to r_valid; legal range 1..4.
- STALL_PERIOD, 0, when nonzero, the request that would be the STALL_PERIOD-th grant is held off for one cycle; 0 disables stalling.
- ERR_RDATA, 32'hBADA_CCE5, r_rdata returned on out-of-range reads.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- add_i  in  32  byte address; bits [1:0] ignored
- wen_i  in  1  1=read, 0=write (TCDM polarity)
- wdata_i  in  32  write data
- be_i  in  4  byte enables for writes
- gnt_o  out  1  grant; combinational from req_i and the stall state
- r_valid_o  out  1  response valid
- r_rdata_o  out  32  read data
- r_opc_o  out  1  error: 1 = address outside the window

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, stall counter=0, response pipeline empty.
- Memory contents are not reset.
- Handshake: a transfer occurs in any cycle where req_i && gnt_o.
- The requester holds add_i, wen_i, wdata_i and be_i stable while req_i=1 and gnt_o=0.
- gnt_o = req_i && !stall_now. There is no backpressure on responses; the requester must always accept r_valid.
- Stall counter, when STALL_PERIOD>0:
  - It counts granted transfers, wrapping at STALL_PERIOD.
  - When count == STALL_PERIOD-1 and req_i=1, the block asserts stall_now for exactly one cycle and gnt_o=0. It grants the same request the next cycle, then the counter wraps to 0.
  - Two consecutive stall cycles never occur.
- Decode: in_range = (add_i − BASE_ADDR) < NUM_WORDS*4, computed in unsigned 32-bit arithmetic. Word index = offset[log2(NUM_WORDS)+1:2].
- Writes:
  - In range: applied at the grant edge, byte-masked by be_i.
  - be_i=0: no array change, but a normal ack is still returned.
  - Out of range: no array change.
- Reads: array data sampled at the grant edge (read-first). A read granted one cycle after a write to the same word returns the new data.
- Response pipeline: a shift register of RESP_LATENCY stages carrying {valid, opc, rdata}.
  - A transfer granted at edge N produces r_valid_o=1 during the cycle after edge N+RESP_LATENCY−1. For latency 1 this is the cycle immediately after the grant.
  - Throughput is one transfer per cycle. Responses are returned strictly in grant order.
- Response contents:
  - Write response: r_rdata_o=0, r_opc_o=0 in range; r_opc_o=1 out of range.
  - Out-of-range read: r_rdata_o=ERR_RDATA, r_opc_o=1.
  - r_rdata_o and r_opc_o read 0 whenever r_valid_o=0.
- Reset mid-operation: in-flight responses are dropped (r_valid_o=0 immediately, asynchronously). Committed writes persist.
- No state machine beyond the stall counter (IDLE/STALL as a one-bit flag). Illegal parameter values are caught by elaboration-time assertions.

Decomposition:
- Shared package tcdm_pkg: a tcdm_resp_t struct {valid, opc, rdata}, the ERR_RDATA default, and a TCDM_WEN_READ=1'b1 constant.
- One natural sub-module: tcdm_resp_pipe (parameterised depth, carries tcdm_resp_t, async reset clears the valid bits).
- The memory array is inferred in the top level.

Test Plan:
- Write 32'hDEAD_BEEF, be=4'hF, to BASE_ADDR+0x10, then read it back, RESP_LATENCY=1 -> gnt same cycle as req; r_valid one cycle after each grant; read returns DEADBEEF, r_opc=0.
- Write be=4'b0010, wdata=32'h0000_5500, over the stored DEADBEEF word, then read -> 32'hDEAD_55EF.
- Read 0x1BFF_FFFC and BASE_ADDR+NUM_WORDS*4 -> r_opc=1, rdata=BADACCE5. A write to the same addresses leaves the array unchanged.
- RESP_LATENCY=3, 8 back-to-back reads of distinct words -> 8 grants in 8 cycles; r_valid high for 8 consecutive cycles starting 3 cycles after the first grant; data in order.
- STALL_PERIOD=4, 10 back-to-back requests -> gnt low on the 4th and 8th request's first cycle only; 10 responses in 12 cycles.
- rst_ni asserted with 2 responses in flight (latency 3) -> r_valid drops that cycle and never appears. A previously written word still reads back correctly after reset.
